conv_interleaver_branches: RTL and testbench

Upstream stage of the convolutional byte interleaver. Accepts one byte per valid cycle, distributes bytes round-robin over 12 branches with delays of 0, M, 2M … 11M visits, and presents all branch tap outputs plus a registered branch select to the 12-to-1 output multiplexer. Packet sync realigns the commutator so every sync byte enters branch 1.

---
 rtl/conv_interleaver_branches_pkg.sv | 16 +
 rtl/conv_interleaver_branches_delay.sv | 36 +++
 rtl/conv_interleaver_branches.sv | 104 ++++++++++
 tb/tb_conv_interleaver_branches.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_interleaver_branches_pkg.sv
// rtl/conv_interleaver_branches_pkg.sv - shared constants and types for the interleaver branch stage
package conv_interleaver_branches_pkg;

    localparam int          IL_BRANCHES  = 12;
    localparam int          IL_M         = 17;
    localparam int          IL_W         = 8;
    localparam logic [7:0]  IL_SYNC_BYTE = 8'h47;

    typedef logic [3:0] branch_idx_t;

    // Commutator successor: 1..IL_BRANCHES, wrapping back to 1
    function automatic branch_idx_t il_next_branch(input branch_idx_t b);
        return (b == branch_idx_t'(IL_BRANCHES)) ? branch_idx_t'(1) : b + branch_idx_t'(1);
    endfunction

endpackage

// File: rtl/conv_interleaver_branches_delay.sv
// rtl/conv_interleaver_branches_delay.sv - one interleaver branch: DEPTH-byte shift register with registered tap
module il_branch_delay
    import conv_interleaver_branches_pkg::*;
#(
    parameter int DEPTH = IL_M,
    parameter int W     = IL_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_shift_en,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_tap
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_tap;

    // Storage clears on reset so unfilled visits emit 0x00
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
            r_tap <= '0;
        end else if (i_shift_en) begin
            r_mem[0] <= i_data;
            for (int k = 1; k < DEPTH; k++) begin
                r_mem[k] <= r_mem[k-1];
            end
            r_tap <= r_mem[DEPTH-1];
        end
    end

    assign o_tap = r_tap;

endmodule

// File: rtl/conv_interleaver_branches.sv
// rtl/conv_interleaver_branches.sv - commutator, sync alignment and branch delay lines of the byte interleaver
module conv_interleaver_branches
    import conv_interleaver_branches_pkg::*;
#(
    parameter int BRANCHES = IL_BRANCHES,
    parameter int M        = IL_M,
    parameter int W        = IL_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] data_in,
    input  logic         in_valid,
    input  logic         sync_in,
    output logic [3:0]   sel,
    output logic         out_valid,
    output logic [W-1:0] m_out1,
    output logic [W-1:0] m_out2,
    output logic [W-1:0] m_out3,
    output logic [W-1:0] m_out4,
    output logic [W-1:0] m_out5,
    output logic [W-1:0] m_out6,
    output logic [W-1:0] m_out7,
    output logic [W-1:0] m_out8,
    output logic [W-1:0] m_out9,
    output logic [W-1:0] m_out10,
    output logic [W-1:0] m_out11,
    output logic [W-1:0] m_out12,
    output logic         sync_err
);

    branch_idx_t   r_cidx;
    branch_idx_t   r_sel;
    logic          r_out_valid;
    logic          r_sync_err;
    logic [W-1:0]  r_tap1;

    branch_idx_t   w_eff;
    logic          w_sync;
    logic [BRANCHES:2] w_shift_en;
    logic [W-1:0]  w_taps [1:BRANCHES];

    // A sync byte is forced onto branch 1 regardless of where the commutator sits
    assign w_sync = in_valid && sync_in;
    assign w_eff  = w_sync ? branch_idx_t'(1) : r_cidx;

    always_comb begin
        w_shift_en = '0;
        for (int j = 2; j <= BRANCHES; j++) begin
            w_shift_en[j] = in_valid && (w_eff == branch_idx_t'(j));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cidx      <= branch_idx_t'(1);
            r_sel       <= branch_idx_t'(1);
            r_out_valid <= 1'b0;
            r_sync_err  <= 1'b0;
            r_tap1      <= '0;
        end else begin
            r_out_valid <= in_valid;
            r_sync_err  <= w_sync && (r_cidx != branch_idx_t'(1));
            if (in_valid) begin
                r_sel  <= w_eff;
                r_cidx <= il_next_branch(w_eff);
                if (w_eff == branch_idx_t'(1)) begin
                    r_tap1 <= data_in;
                end
            end
        end
    end

    assign w_taps[1] = r_tap1;

    for (genvar j = 2; j <= BRANCHES; j++) begin : g_branch
        il_branch_delay #(
            .DEPTH ((j - 1) * M),
            .W     (W)
        ) u_delay (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_shift_en (w_shift_en[j]),
            .i_data     (data_in),
            .o_tap      (w_taps[j])
        );
    end

    assign sel       = r_sel;
    assign out_valid = r_out_valid;
    assign sync_err  = r_sync_err;
    assign m_out1    = w_taps[1];
    assign m_out2    = w_taps[2];
    assign m_out3    = w_taps[3];
    assign m_out4    = w_taps[4];
    assign m_out5    = w_taps[5];
    assign m_out6    = w_taps[6];
    assign m_out7    = w_taps[7];
    assign m_out8    = w_taps[8];
    assign m_out9    = w_taps[9];
    assign m_out10   = w_taps[10];
    assign m_out11   = w_taps[11];
    assign m_out12   = w_taps[12];

endmodule

// File: tb/tb_conv_interleaver_branches.sv
// tb/tb_conv_interleaver_branches.sv - self-checking bench for conv_interleaver_branches
module tb_conv_interleaver_branches;
    import conv_interleaver_branches_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = '0;
    logic       in_valid = 1'b0;
    logic       sync_in = 1'b0;
    logic [3:0] sel;
    logic       out_valid;
    logic       sync_err;
    logic [7:0] m_out1, m_out2, m_out3, m_out4, m_out5, m_out6;
    logic [7:0] m_out7, m_out8, m_out9, m_out10, m_out11, m_out12;
    logic [7:0] taps [1:12];

    assign taps[1]  = m_out1;
    assign taps[2]  = m_out2;
    assign taps[3]  = m_out3;
    assign taps[4]  = m_out4;
    assign taps[5]  = m_out5;
    assign taps[6]  = m_out6;
    assign taps[7]  = m_out7;
    assign taps[8]  = m_out8;
    assign taps[9]  = m_out9;
    assign taps[10] = m_out10;
    assign taps[11] = m_out11;
    assign taps[12] = m_out12;

    conv_interleaver_branches dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .sync_in   (sync_in),
        .sel       (sel),
        .out_valid (out_valid),
        .m_out1    (m_out1),
        .m_out2    (m_out2),
        .m_out3    (m_out3),
        .m_out4    (m_out4),
        .m_out5    (m_out5),
        .m_out6    (m_out6),
        .m_out7    (m_out7),
        .m_out8    (m_out8),
        .m_out9    (m_out9),
        .m_out10   (m_out10),
        .m_out11   (m_out11),
        .m_out12   (m_out12),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: per-branch FIFOs pre-filled with zeros
    int         m_cidx, m_sel, m_ov, m_serr;
    int         m_tap [1:12];
    logic [7:0] m_q [1:12][$];

    task automatic mdl_reset();
        m_cidx = 1; m_sel = 1; m_ov = 0; m_serr = 0;
        for (int j = 1; j <= 12; j++) begin
            m_tap[j] = 0;
            m_q[j].delete();
            for (int k = 0; k < (j - 1) * IL_M; k++) m_q[j].push_back(8'h00);
        end
    endtask

    task automatic mdl_step(input logic [7:0] d, input logic v, input logic s);
        int eff;
        m_ov   = v ? 1 : 0;
        m_serr = (v && s && m_cidx != 1) ? 1 : 0;
        if (v) begin
            eff = s ? 1 : m_cidx;
            m_sel = eff;
            if (eff == 1) m_tap[1] = d;
            else begin
                m_q[eff].push_back(d);
                m_tap[eff] = m_q[eff].pop_front();
            end
            m_cidx = (eff == 12) ? 1 : eff + 1;
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " sel"}, sel, m_sel);
        chk({tag, " out_valid"}, out_valid, m_ov);
        chk({tag, " sync_err"}, sync_err, m_serr);
        for (int j = 1; j <= 12; j++) chk($sformatf("%s m_out%0d", tag, j), taps[j], m_tap[j]);
    endtask

    task automatic drive(input logic [7:0] d, input logic v, input logic s);
        @(negedge clk);
        data_in = d; in_valid = v; sync_in = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0; sync_in = 1'b0;
        mdl_step(d, v, s);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " sel"}, sel, 1);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " sync_err"}, sync_err, 0);
        for (int j = 1; j <= 12; j++) chk($sformatf("%s m_out%0d", tag, j), taps[j], 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; sync_in = 1'b0;
        #1;
        chk_reset_state("reset");
        mdl_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       s;
        int         sel;
        int         ov;
        int         serr;
        int         m1;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic [7:0] d, input logic v, input logic s,
                       input int es, input int eov, input int eserr, input int em1);
        vec_t t;
        t.d = d; t.v = v; t.s = s; t.sel = es; t.ov = eov; t.serr = eserr; t.m1 = em1;
        tbl.push_back(t);
    endtask

    logic [7:0] xs [$];

    initial begin
        // Hand-computed vectors: first byte, gaps, sync off-branch, sync+wrap, sync on branch 1
        add(8'hA5, 1, 0, 1, 1, 0, 8'hA5);
        add(8'h11, 1, 0, 2, 1, 0, 8'hA5);
        add(8'h00, 0, 0, 2, 0, 0, 8'hA5);
        add(8'h22, 1, 0, 3, 1, 0, 8'hA5);
        add(8'h47, 1, 1, 1, 1, 1, 8'h47);
        add(8'h33, 1, 0, 2, 1, 0, 8'h47);
        add(8'h00, 0, 0, 2, 0, 0, 8'h47);
        for (int i = 3; i <= 11; i++) add(8'h60 + 8'(i), 1, 0, i, 1, 0, 8'h47);
        add(8'h47, 1, 1, 1, 1, 1, 8'h47);
        add(8'h70, 1, 0, 2, 1, 0, 8'h47);
        for (int i = 3; i <= 12; i++) add(8'h80 + 8'(i), 1, 0, i, 1, 0, 8'h47);
        add(8'h47, 1, 1, 1, 1, 0, 8'h47);
        add(8'h90, 1, 0, 2, 1, 0, 8'h47);

        repeat (2) @(negedge clk);
        chk_reset_state("power-on reset");
        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].d, tbl[i].v, tbl[i].s);
            chk($sformatf("vec%0d sel", i), sel, tbl[i].sel);
            chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].ov);
            chk($sformatf("vec%0d sync_err", i), sync_err, tbl[i].serr);
            chk($sformatf("vec%0d m_out1", i), m_out1, tbl[i].m1);
            for (int j = 2; j <= 12; j++) chk($sformatf("vec%0d m_out%0d", i, j), taps[j], 0);
        end

        // Commutator wrap over 24 bytes
        do_reset();
        for (int i = 0; i < 24; i++) begin
            drive(8'hC0 + 8'(i), 1, 0);
            chk($sformatf("wrap%0d sel", i), sel, (i % 12) + 1);
            for (int j = 2; j <= 12; j++) chk($sformatf("wrap%0d m_out%0d", i, j), taps[j], 0);
        end

        // Branch delay with continuous incrementing stream
        do_reset();
        for (int i = 0; i < 2256; i++) begin
            drive(8'(i), 1, 0);
            chk_model($sformatf("delay%0d", i));
            if (i == 193)  chk("branch2 visit17", m_out2, 0);
            if (i == 205)  chk("branch2 visit18", m_out2, 1);
            if (i == 2243) chk("branch12 visit187", m_out12, 0);
            if (i == 2255) chk("branch12 visit188", m_out12, 11);
        end

        // Sync realign at cidx=5 with populated taps
        for (int i = 0; i < 4; i++) begin
            drive(8'hB0 + 8'(i), 1, 0);
            chk_model($sformatf("presync%0d", i));
        end
        drive(IL_SYNC_BYTE, 1, 1);
        chk("realign sel", sel, 1);
        chk("realign sync_err", sync_err, 1);
        chk("realign m_out1", m_out1, 8'h47);
        chk_model("realign");
        drive(8'hC7, 1, 0);
        chk("after realign sel", sel, 2);
        chk("after realign sync_err", sync_err, 0);
        chk_model("after realign");

        // Random gaps, 10 packets of 204 bytes, mux output vs reference interleaver
        do_reset();
        xs.delete();
        for (int p = 0; p < 10; p++) begin
            for (int b = 0; b < 204; b++) begin
                int gap, n, j, dly, expv;
                logic [7:0] d;
                gap = $urandom_range(0, 7);
                for (int g = 0; g < gap; g++) begin
                    drive(8'h00, 0, 0);
                    chk("gap out_valid", out_valid, 0);
                end
                d = 8'($urandom_range(0, 255));
                if (b == 0) d = IL_SYNC_BYTE;
                xs.push_back(d);
                n = xs.size() - 1;
                drive(d, 1, b == 0);
                j = (n % 12) + 1;
                dly = (j - 1) * IL_M * 12;
                expv = (n >= dly) ? int'(xs[n - dly]) : 0;
                chk($sformatf("pkt%0d byte%0d sel", p, b), sel, j);
                chk($sformatf("pkt%0d byte%0d mux", p, b), taps[sel], expv);
                chk($sformatf("pkt%0d byte%0d sync_err", p, b), sync_err, 0);
            end
        end

        // Asynchronous reset mid-packet
        for (int i = 0; i < 50; i++) drive(8'hD0 + 8'(i), 1, i == 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async reset");
        mdl_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'hE1, 1, 0);
        chk("post-reset sel", sel, 1);
        chk("post-reset m_out1", m_out1, 8'hE1);
        chk_model("post-reset first");
        for (int i = 0; i < 30; i++) begin
            drive(8'hF0 + 8'(i), 1, 0);
            chk_model($sformatf("post-reset%0d", i));
            chk($sformatf("post-reset%0d m_out2", i), m_out2, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
